// File: rtl/maze_pkg.sv
// Shared maze definitions: PS/2 key codes, step directions, controller states.
package maze_pkg;

  localparam int MAZE_DIM_DEFAULT = 64;

  localparam logic [7:0] KEY_UP    = 8'hEA;
  localparam logic [7:0] KEY_DOWN  = 8'hE4;
  localparam logic [7:0] KEY_LEFT  = 8'hD6;
  localparam logic [7:0] KEY_RIGHT = 8'hE8;
  localparam logic [7:0] KEY_W     = 8'h3A;
  localparam logic [7:0] KEY_S     = 8'h36;
  localparam logic [7:0] KEY_A     = 8'h38;
  localparam logic [7:0] KEY_D     = 8'h46;

  typedef enum logic [2:0] {DIR_NONE, DIR_N, DIR_S, DIR_W, DIR_E} dir_t;
  typedef enum logic [1:0] {IDLE, CHECK, HOLD} state_t;

  // Arrow keys and WASD map onto the same four steps; anything else is no step.
  function automatic dir_t key_to_dir(input logic [7:0] code);
    case (code)
      KEY_UP, KEY_W:    return DIR_N;
      KEY_DOWN, KEY_S:  return DIR_S;
      KEY_LEFT, KEY_A:  return DIR_W;
      KEY_RIGHT, KEY_D: return DIR_E;
      default:          return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/maze_tile_lookup.sv
// Combinational path-bitmap lookup: returns 1 when tile (tx, ty) is open.
module maze_tile_lookup
  import maze_pkg::*;
#(
  parameter int MAZE_DIM = MAZE_DIM_DEFAULT,
  parameter int COORD_W  = 7
) (
  input  logic [MAZE_DIM*MAZE_DIM-1:0] path_data,
  input  logic [COORD_W-1:0]           tx,
  input  logic [COORD_W-1:0]           ty,
  output logic                         open
);

  localparam int IDX_W = $clog2(MAZE_DIM * MAZE_DIM);

  logic [12:0] idx;
  logic        in_range;

  // Index in 13 bits; coordinates or indices beyond the bitmap read as wall.
  assign idx      = 13'(ty) * 13'(MAZE_DIM) + 13'(tx);
  assign in_range = (13'(tx) < 13'(MAZE_DIM)) && (13'(ty) < 13'(MAZE_DIM))
                    && (idx < 13'(MAZE_DIM * MAZE_DIM));
  assign open     = in_range && path_data[idx[IDX_W-1:0]];

endmodule

// File: rtl/avatar_move_ctrl.sv
// Moves the player avatar one tile per key press through the carved maze,
// rejecting steps into walls or off the maze edge, with a cooldown between keys.
module avatar_move_ctrl
  import maze_pkg::*;
#(
  parameter int MAZE_DIM = MAZE_DIM_DEFAULT,
  parameter int COORD_W  = 7,
  parameter int COOLDOWN = 2_000_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         kb_buf_empty,
  input  logic [7:0]                   key_code,
  output logic                         rd_key_code,
  input  logic [MAZE_DIM*MAZE_DIM-1:0] path_data,
  input  logic [COORD_W-1:0]           maze_width,
  input  logic [COORD_W-1:0]           maze_height,
  output logic [COORD_W-1:0]           char_x,
  output logic [COORD_W-1:0]           char_y,
  output logic                         at_goal,
  output logic                         bump,
  output logic [15:0]                  move_count,
  output state_t                       state
);

  localparam int CNT_W = $clog2(COOLDOWN + 1);

  // Handshake: the FIFO presents key_code whenever kb_buf_empty=0 and pops on
  // any cycle rd_key_code=1; a key is consumed only by that one-cycle strobe.

  logic [CNT_W-1:0]   cnt;
  logic [7:0]         key_reg;
  logic               rd_pulse;
  dir_t               dir;
  logic [COORD_W-1:0] tx;
  logic [COORD_W-1:0] ty;
  logic               edge_hit;
  logic               tile_open;
  logic               goal_here;

  // While play is disabled the strobe follows the empty flag so the FIFO drains.
  assign rd_key_code = reset && (enable ? rd_pulse : !kb_buf_empty);

  assign goal_here = (char_x == maze_width - COORD_W'(1))
                  && (char_y == maze_height - COORD_W'(1));

  always_comb begin
    dir      = key_to_dir(key_reg);
    tx       = char_x;
    ty       = char_y;
    edge_hit = 1'b0;
    case (dir)
      DIR_N: begin ty = char_y - COORD_W'(1); edge_hit = (char_y == '0); end
      DIR_S: begin ty = char_y + COORD_W'(1); edge_hit = (char_y == maze_height - COORD_W'(1)); end
      DIR_W: begin tx = char_x - COORD_W'(1); edge_hit = (char_x == '0); end
      DIR_E: begin tx = char_x + COORD_W'(1); edge_hit = (char_x == maze_width - COORD_W'(1)); end
      default: ;
    endcase
  end

  maze_tile_lookup #(
    .MAZE_DIM (MAZE_DIM),
    .COORD_W  (COORD_W)
  ) u_lookup (
    .path_data (path_data),
    .tx        (tx),
    .ty        (ty),
    .open      (tile_open)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      char_x     <= '0;
      char_y     <= '0;
      at_goal    <= 1'b0;
      bump       <= 1'b0;
      rd_pulse   <= 1'b0;
      move_count <= '0;
      cnt        <= '0;
      key_reg    <= '0;
    end else if (!enable) begin
      state      <= IDLE;
      char_x     <= '0;
      char_y     <= '0;
      at_goal    <= 1'b0;
      bump       <= 1'b0;
      rd_pulse   <= 1'b0;
      move_count <= '0;
      cnt        <= '0;
    end else begin
      rd_pulse <= 1'b0;
      bump     <= 1'b0;
      at_goal  <= goal_here;
      case (state)
        IDLE: begin
          if (!kb_buf_empty) begin
            key_reg  <= key_code;
            rd_pulse <= 1'b1;
            state    <= CHECK;
          end
        end
        CHECK: begin
          state <= HOLD;
          cnt   <= CNT_W'(COOLDOWN - 1);
          // Once the goal is reached, every key is swallowed without a bump.
          if (!at_goal && dir != DIR_NONE) begin
            if (edge_hit || !tile_open) begin
              bump <= 1'b1;
            end else begin
              char_x <= tx;
              char_y <= ty;
              if (move_count != 16'hFFFF) move_count <= move_count + 16'd1;
            end
          end
        end
        HOLD: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avatar_move_ctrl.sv
// Bench for avatar_move_ctrl: keyboard FIFO model, rule-level avatar model
// compared every cycle, plus hand-computed checkpoints.
module tb_avatar_move_ctrl;
  import maze_pkg::*;

  localparam int MD = 64;
  localparam int CW = 7;
  localparam int CD = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              kb_buf_empty;
  logic [7:0]        key_code;
  logic              rd_key_code;
  logic [MD*MD-1:0]  path_data;
  logic [CW-1:0]     maze_width;
  logic [CW-1:0]     maze_height;
  logic [CW-1:0]     char_x;
  logic [CW-1:0]     char_y;
  logic              at_goal;
  logic              bump;
  logic [15:0]       move_count;
  state_t            state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  avatar_move_ctrl #(
    .MAZE_DIM (MD),
    .COORD_W  (CW),
    .COOLDOWN (CD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .kb_buf_empty (kb_buf_empty),
    .key_code     (key_code),
    .rd_key_code  (rd_key_code),
    .path_data    (path_data),
    .maze_width   (maze_width),
    .maze_height  (maze_height),
    .char_x       (char_x),
    .char_y       (char_y),
    .at_goal      (at_goal),
    .bump         (bump),
    .move_count   (move_count),
    .state        (state)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] kb_q[$];   // keyboard FIFO contents
  logic [7:0] exp_q[$];  // keys taken by the model, awaiting their verdict
  int n_cmp = 0;
  int n_err = 0;
  int m_x, m_y, m_cnt;
  bit m_goal, m_bump, m_rd;
  int edge_no = 0;
  int take_edge = -100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Plain rule evaluation of one key against the current maze.
  function automatic void apply_key(input logic [7:0] k, input bit goal_before);
    int dx = 0;
    int dy = 0;
    int tx, ty;
    case (k)
      8'hEA, 8'h3A: dy = -1;
      8'hE4, 8'h36: dy = 1;
      8'hD6, 8'h38: dx = -1;
      8'hE8, 8'h46: dx = 1;
      default: ;
    endcase
    if (goal_before || (dx == 0 && dy == 0)) return;
    tx = m_x + dx;
    ty = m_y + dy;
    if (tx < 0 || ty < 0 || tx >= int'(maze_width) || ty >= int'(maze_height))
      m_bump = 1'b1;
    else if (path_data[ty*MD + tx] == 1'b0)
      m_bump = 1'b1;
    else begin
      m_x = tx;
      m_y = ty;
      if (m_cnt < 65535) m_cnt++;
    end
  endfunction

  // Effect of one clock edge: key taken when idle long enough, verdict one
  // edge later, next key no sooner than COOLDOWN+2 edges after the previous.
  task automatic model_step();
    bit goal_now;
    edge_no++;
    if (!reset || !enable) begin
      m_x = 0; m_y = 0; m_cnt = 0; m_goal = 1'b0; m_bump = 1'b0;
      exp_q.delete();
      take_edge = -100;
      m_rd = reset && !enable && (kb_q.size() != 0);
      return;
    end
    m_bump = 1'b0;
    m_rd   = 1'b0;
    goal_now = (m_x == int'(maze_width) - 1) && (m_y == int'(maze_height) - 1);
    if (exp_q.size() != 0 && edge_no == take_edge + 1) apply_key(exp_q.pop_front(), m_goal);
    m_goal = goal_now;
    if (kb_q.size() != 0 && edge_no >= take_edge + CD + 2) begin
      exp_q.push_back(kb_q[0]);
      take_edge = edge_no;
      m_rd = 1'b1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic fifo_drive();
    kb_buf_empty = (kb_q.size() == 0);
    key_code     = (kb_q.size() != 0) ? kb_q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] k);
    kb_q.push_back(k);
    fifo_drive();
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    check("char_x", 32'(char_x), 32'(m_x));
    check("char_y", 32'(char_y), 32'(m_y));
    check("at_goal", 32'(at_goal), 32'(m_goal));
    check("bump", 32'(bump), 32'(m_bump));
    check("move_count", 32'(move_count), 32'(m_cnt));
    check("rd_key_code", 32'(rd_key_code), 32'(m_rd));
    if (rd_key_code === 1'b1 && kb_q.size() != 0) void'(kb_q.pop_front());
    fifo_drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input logic [7:0] k);
    push(k);
    tick();
    tick();
  endtask

  task automatic restart(input int w, input int h);
    enable = 1'b0;
    tick();
    maze_width  = CW'(w);
    maze_height = CW'(h);
    enable = 1'b1;
    tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    enable = 1'b0;
    path_data = '1;
    maze_width = 7'd16;
    maze_height = 7'd16;
    fifo_drive();
    #1 reset = 1'b0;
    #1;
    check("lit_rst_x", 32'(char_x), 0);
    check("lit_rst_count", 32'(move_count), 0);
    check("lit_rst_rd", 32'(rd_key_code), 0);
    run(2);

    // Drain with play disabled: three keys leave in three cycles.
    reset = 1'b1;
    push(8'h46); push(8'h36); push(8'h46);
    run(3);
    check("lit_drain_empty", 32'(kb_q.size()), 0);
    check("lit_drain_x", 32'(char_x), 0);
    tick();
    enable = 1'b1;
    tick();

    // Open move and key spacing.
    push(8'h46); push(8'h36);
    tick();
    check("lit_open_rd1", 32'(rd_key_code), 1);
    check("lit_open_x0", 32'(char_x), 0);
    tick();
    check("lit_open_x1", 32'(char_x), 1);
    check("lit_open_cnt1", 32'(move_count), 1);
    check("lit_open_rd0", 32'(rd_key_code), 0);
    run(3);
    tick();
    check("lit_gap_rd_low", 32'(rd_key_code), 0);
    tick();
    check("lit_gap_rd_high", 32'(rd_key_code), 1);
    tick();
    check("lit_open_y1", 32'(char_y), 1);
    run(CD);

    // Asynchronous reset in the middle of HOLD.
    push(8'h46);
    run(3);
    reset = 1'b0;
    #1;
    check("lit_midhold_x", 32'(char_x), 0);
    check("lit_midhold_cnt", 32'(move_count), 0);
    tick();
    reset = 1'b1;
    tick();
    check("lit_state_idle", 32'(state), 32'(IDLE));

    // Edges at the origin, then the east edge at (15,5).
    press(8'hEA);
    check("lit_edge_up_bump", 32'(bump), 1);
    run(CD);
    press(8'hD6);
    check("lit_edge_left_bump", 32'(bump), 1);
    check("lit_edge_cnt", 32'(move_count), 0);
    run(CD);
    for (int i = 0; i < 15; i++) push(8'hE8);
    for (int i = 0; i < 5; i++) push(8'hE4);
    run(20 * (CD + 2));
    check("lit_walk_x", 32'(char_x), 15);
    check("lit_walk_y", 32'(char_y), 5);
    press(8'hE8);
    check("lit_east_bump", 32'(bump), 1);
    check("lit_east_x", 32'(char_x), 15);
    run(CD);

    // Wall below the origin, then opened.
    enable = 1'b0;
    tick();
    path_data[1*MD + 0] = 1'b0;
    enable = 1'b1;
    tick();
    press(8'h36);
    check("lit_wall_bump", 32'(bump), 1);
    check("lit_wall_y", 32'(char_y), 0);
    run(CD);
    path_data[1*MD + 0] = 1'b1;
    press(8'h36);
    check("lit_open_wall_y", 32'(char_y), 1);
    check("lit_open_wall_bump", 32'(bump), 0);
    run(CD);

    // Goal in a 2x2 maze; further keys are swallowed.
    restart(2, 2);
    press(8'h46); run(CD);
    press(8'h36); run(CD);
    check("lit_goal", 32'(at_goal), 1);
    check("lit_goal_xy", 32'({char_x, char_y}), 32'({7'd1, 7'd1}));
    press(8'h38);
    check("lit_goal_nobump", 32'(bump), 0);
    check("lit_goal_x", 32'(char_x), 1);
    run(CD);
    check("lit_goal_cnt", 32'(move_count), 2);

    // Junk key, then counter saturation.
    restart(16, 16);
    press(8'h29);
    check("lit_junk_bump", 32'(bump), 0);
    check("lit_junk_x", 32'(char_x), 0);
    run(CD);
    force dut.move_count = 16'hFFFF;
    #1 release dut.move_count;
    m_cnt = 65535;
    press(8'h46);
    check("lit_sat_cnt", 32'(move_count), 32'h0000_FFFF);
    check("lit_sat_x", 32'(char_x), 1);
    run(CD);

    // 1x1 maze: goal right after enable, keys discarded.
    restart(1, 1);
    check("lit_1x1_goal", 32'(at_goal), 1);
    press(8'h46);
    check("lit_1x1_bump", 32'(bump), 0);
    check("lit_1x1_x", 32'(char_x), 0);
    run(CD + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/avatar_move_ctrl.md
Name: avatar_move_ctrl

Overview:
- Consumes key codes from the PS/2 keyboard decoder and moves the player avatar through the carved maze, one tile per key press.
- Checks every step against the maze path bitmap and the maze dimensions.
- Drives avatar coordinates, move count and goal status to the maze renderer.
- Sits between the keyboard decoder (upstream), the maze carver (maze data and finish) and the renderer (downstream).

Parameters:
- MAZE_DIM, 64: side length of the path bitmap; bitmap width is MAZE_DIM*MAZE_DIM.
- COORD_W, 7: width of coordinate and dimension signals.
- COOLDOWN, 2_000_000: clk cycles spent in HOLD after each accepted or rejected key; rate limit.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  play enable. Low = maze not ready: avatar is held at start and keys are drained.
- kb_buf_empty  input  1  keyboard FIFO empty flag.
- key_code  input  8  head-of-FIFO key code; valid whenever kb_buf_empty=0.
- rd_key_code  output  1  one-cycle pop strobe to the keyboard FIFO.
- path_data  input  MAZE_DIM*MAZE_DIM  path bitmap; bit index y*MAZE_DIM+x; 1=open, 0=wall.
- maze_width  input  COORD_W  maze width in tiles, legal range 1..MAZE_DIM.
- maze_height  input  COORD_W  maze height in tiles, legal range 1..MAZE_DIM.
- char_x  output  COORD_W  avatar column.
- char_y  output  COORD_W  avatar row.
- at_goal  output  1  high while the avatar is at (maze_width-1, maze_height-1).
- bump  output  1  one-cycle pulse when a move is rejected (wall or edge).
- move_count  output  16  accepted moves since start; saturates at 16'hFFFF.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; char_x=0, char_y=0; at_goal=0; bump=0; rd_key_code=0; move_count=0; cooldown counter=0.
- enable=0, synchronous, overrides everything:
  - Same values as reset, except rd_key_code = ~kb_buf_empty, so the FIFO drains.
  - When enable returns high, play starts from IDLE.
- IDLE:
  - If kb_buf_empty=0: latch key_code into key_reg, pulse rd_key_code for exactly 1 cycle, go to CHECK.
  - Otherwise stay in IDLE.
- CHECK (1 cycle), decode key_reg:
  - UP/W: target=(x, y-1).
  - DOWN/S: target=(x, y+1).
  - LEFT/A: target=(x-1, y).
  - RIGHT/D: target=(x+1, y).
  - Any other code: discard silently, go to HOLD, no bump.
  - If at_goal=1: every key is discarded (no move, no bump).
- Legality of the target:
  - Edge reject: UP with y=0; LEFT with x=0; DOWN with y=maze_height-1; RIGHT with x=maze_width-1. No wrap-around.
  - Wall reject: path_data[ty*MAZE_DIM+tx]=0.
  - Compute the index in 13 bits; never index past the bitmap.
- Accepted move:
  - char_x/char_y update on the clock edge leaving CHECK.
  - move_count increments and saturates at 16'hFFFF.
  - at_goal is set next cycle if the new position is (maze_width-1, maze_height-1).
- Rejected move: bump=1 for the cycle after CHECK; position unchanged.
- HOLD: count COOLDOWN-1 down to 0, then go to IDLE. Keys arriving during HOLD stay queued in the FIFO.
- Latency: key visible in IDLE → position update = 2 clk edges. Maximum throughput = one key per COOLDOWN+2 cycles.
- 1x1 maze: at_goal=1 immediately after enable rises (next cycle); all keys are discarded.
- A dimension change while enable=1 is not re-validated until the next move; the position is not clamped.

Decomposition:
- Shared package maze_pkg:
  - Key code constants: KEY_UP=8'hEA, KEY_DOWN=8'hE4, KEY_LEFT=8'hD6, KEY_RIGHT=8'hE8, KEY_W=8'h3A, KEY_S=8'h36, KEY_A=8'h38, KEY_D=8'h46.
  - Direction encoding: NONE, N, S, W, E.
  - State encoding: IDLE, CHECK, HOLD.
  - MAZE_DIM default.
- One natural combinational sub-module, maze_tile_lookup: (path_data, tx, ty) → open bit. It is reusable by the renderer and a future solver.

Test Plan:
- Reset and enable: reset=0 mid-HOLD, then release → char=(0,0), move_count=0, state IDLE next cycle. With enable=0 and 3 queued keys, the FIFO drains in 3 cycles and the position stays (0,0).
- Open move: COOLDOWN=4, all-ones bitmap, 16x16 maze, KEY_D → char_x=1 two edges after the key is visible, move_count=1, rd_key_code high exactly 1 cycle, next key taken no earlier than 6 cycles later.
- Edges: at (0,0) press KEY_UP then KEY_LEFT → two bump pulses, position (0,0), move_count=0. At (15,5) in a 16-wide maze press KEY_RIGHT → bump, x stays 15.
- Wall: bit (1*64+0)=0, press KEY_S at (0,0) → bump, y stays 0. Set the bit to 1 and repeat → y=1.
- Goal: 2x2 open maze, press D then S → at_goal=1 at (1,1). A further KEY_A causes no move, no bump, move_count=2.
- Junk and saturation: key 8'h29 → discarded, no bump. Preset move_count=16'hFFFF via force, accept a move → stays 16'hFFFF.
